pkt_axil_write_master: RTL and testbench

Upstream AXI4-Lite write master for the packet validator/sorter slave. It accepts 32-bit packet words on a valid/ready stream and turns each word into a two-beat AXI4-Lite write sequence: a header write to HDR_ADDR, then a commit write to COMMIT_ADDR. It classifies the slave's commit BRESP as valid (2'b00), invalid (2'b01) or error, and keeps saturating statistics. It sits between the packet source and the sorter's AW/W/B channels.

---
 rtl/pkt_axil_write_master.sv | 129 ++++++++++++
 tb/tb_pkt_axil_write_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_axil_write_master.sv
// AXI4-Lite write master: each accepted packet word becomes a header write
// followed by a commit write; the commit response is classified into statistics.
module pkt_axil_write_master #(
  parameter logic [31:0] HDR_ADDR    = 32'h0000_0000,
  parameter logic [31:0] COMMIT_ADDR = 32'h0000_0004,
  parameter int          TIMEOUT     = 64,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_valid,
  input  logic [31:0]      pkt_data,
  output logic             pkt_ready,
  output logic             AWVALID,
  input  logic             AWREADY,
  output logic [31:0]      AWADDR,
  output logic             WVALID,
  input  logic             WREADY,
  output logic [31:0]      WDATA,
  output logic [3:0]       WSTRB,
  input  logic             BVALID,
  output logic             BREADY,
  input  logic [1:0]       BRESP,
  output logic             busy,
  output logic             done,
  output logic [1:0]       last_resp,
  output logic [CNT_W-1:0] valid_cnt,
  output logic [CNT_W-1:0] invalid_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             timeout_flag
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HDR_REQ, HDR_RSP, CMT_REQ, CMT_RSP} state_t;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [TW-1:0] r_tmo;
  logic          w_req_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // AW and W complete independently; a channel whose VALID is already low is finished.
  assign w_req_done = (!AWVALID || AWREADY) && (!WVALID || WREADY);
  assign busy       = (r_state != IDLE);
  assign WSTRB      = 4'hF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_word       <= '0;
      r_tmo        <= '0;
      pkt_ready    <= 1'b0;
      AWVALID      <= 1'b0;
      AWADDR       <= '0;
      WVALID       <= 1'b0;
      WDATA        <= '0;
      BREADY       <= 1'b0;
      done         <= 1'b0;
      last_resp    <= 2'b00;
      valid_cnt    <= '0;
      invalid_cnt  <= '0;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          pkt_ready <= 1'b1;
          if (pkt_valid && pkt_ready) begin
            r_word       <= pkt_data;
            WDATA        <= pkt_data;
            AWADDR       <= HDR_ADDR;
            AWVALID      <= 1'b1;
            WVALID       <= 1'b1;
            pkt_ready    <= 1'b0;
            timeout_flag <= 1'b0;
            r_state      <= HDR_REQ;
          end
        end
        HDR_REQ, CMT_REQ: begin
          if (AWVALID && AWREADY) AWVALID <= 1'b0;
          if (WVALID && WREADY)   WVALID  <= 1'b0;
          if (w_req_done) begin
            BREADY <= 1'b1;
            r_tmo  <= '0;
            if (r_state == HDR_REQ) r_state <= HDR_RSP;
            else                    r_state <= CMT_RSP;
          end
        end
        HDR_RSP, CMT_RSP: begin
          if (BVALID) begin
            BREADY    <= 1'b0;
            last_resp <= BRESP;
            if (r_state == HDR_RSP && BRESP == 2'b00) begin
              AWADDR  <= COMMIT_ADDR;
              WDATA   <= r_word;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              r_state <= CMT_REQ;
            end else begin
              done      <= 1'b1;
              pkt_ready <= 1'b1;
              r_state   <= IDLE;
              // A failed header and any 1x commit response both count as errors.
              if (r_state == HDR_RSP || BRESP[1]) err_cnt     <= sat_inc(err_cnt);
              else if (BRESP[0])                  invalid_cnt <= sat_inc(invalid_cnt);
              else                                valid_cnt   <= sat_inc(valid_cnt);
            end
          end else if (r_tmo == TMO_LAST) begin
            BREADY       <= 1'b0;
            last_resp    <= 2'b11;
            timeout_flag <= 1'b1;
            err_cnt      <= sat_inc(err_cnt);
            done         <= 1'b1;
            pkt_ready    <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pkt_axil_write_master.sv
// Directed bench: a negedge-driven AXI-Lite slave model with per-beat delays and
// responses, a vector table of packets, and hand sequences for reset/saturation.
module tb_pkt_axil_write_master;
  logic        clk, rst;
  logic        pkt_valid;
  logic [31:0] pkt_data;
  logic        pkt_ready;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, last_resp;
  logic        busy, done, timeout_flag;
  logic [15:0] valid_cnt, invalid_cnt, err_cnt;

  logic        d2_pkt_ready, d2_awvalid, d2_wvalid, d2_bready, d2_busy, d2_done, d2_tmo;
  logic [31:0] d2_awaddr, d2_wdata;
  logic [3:0]  d2_wstrb;
  logic [1:0]  d2_last_resp;
  logic [1:0]  d2_valid_cnt, d2_invalid_cnt, d2_err_cnt;

  pkt_axil_write_master dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .busy(busy), .done(done), .last_resp(last_resp),
    .valid_cnt(valid_cnt), .invalid_cnt(invalid_cnt), .err_cnt(err_cnt),
    .timeout_flag(timeout_flag)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  pkt_axil_write_master #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(d2_pkt_ready),
    .AWVALID(d2_awvalid), .AWREADY(AWREADY), .AWADDR(d2_awaddr),
    .WVALID(d2_wvalid), .WREADY(WREADY), .WDATA(d2_wdata), .WSTRB(d2_wstrb),
    .BVALID(BVALID), .BREADY(d2_bready), .BRESP(BRESP),
    .busy(d2_busy), .done(d2_done), .last_resp(d2_last_resp),
    .valid_cnt(d2_valid_cnt), .invalid_cnt(d2_invalid_cnt), .err_cnt(d2_err_cnt),
    .timeout_flag(d2_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_dly[2], w_dly[2];
  logic [1:0]  bresp_cfg[2];
  bit          bhold[2];
  bit          stray_b;

  int          aw_wait, w_wait, beat, w_pend_beat, brun, brun_max;
  bit          aw_pend, w_pend, b_pend, aw_done, w_done, prev_awv, prev_wv, prev_busy;
  logic [31:0] aw_pend_addr, prev_awaddr, prev_wdata, w_pend_data;
  int          n_aw_hs, n_w_hs, n_cmt_aw, n_b_hs, n_stab_err, n_drop_err;
  logic [31:0] cmt_q[$];

  initial begin
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    aw_wait = 0; w_wait = 0; brun = 0; brun_max = 0;
    aw_pend = 0; w_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
    prev_awv = 0; prev_wv = 0; prev_busy = 0;
    n_aw_hs = 0; n_w_hs = 0; n_cmt_aw = 0; n_b_hs = 0; n_stab_err = 0; n_drop_err = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
        aw_pend = 0; w_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
        aw_wait = 0; w_wait = 0; prev_awv = 0; prev_wv = 0; prev_busy = 0;
      end else begin
        if (busy && !prev_busy) brun_max = 0;
        prev_busy = busy;
        if (!busy) begin aw_done = 0; w_done = 0; end
        // Handshakes that completed on the posedge just past.
        if (aw_pend) begin
          n_aw_hs++;
          if (aw_pend_addr == 32'h4) n_cmt_aw++;
          aw_done = 1;
          if (AWVALID) n_drop_err++;
        end
        if (w_pend) begin
          n_w_hs++;
          if (w_pend_beat == 1) cmt_q.push_back(w_pend_data);
          w_done = 1;
          if (WVALID) n_drop_err++;
        end
        if (b_pend) begin
          n_b_hs++;
          aw_done = 0; w_done = 0;
        end
        if (prev_awv && AWVALID && AWADDR != prev_awaddr) n_stab_err++;
        if (prev_wv && WVALID && WDATA != prev_wdata)     n_stab_err++;
        prev_awv = AWVALID; prev_awaddr = AWADDR;
        prev_wv  = WVALID;  prev_wdata  = WDATA;
        if (BREADY) begin brun++; if (brun > brun_max) brun_max = brun; end
        else brun = 0;

        beat    = (AWADDR == 32'h4) ? 1 : 0;
        aw_wait = AWVALID ? aw_wait + 1 : 0;
        w_wait  = WVALID  ? w_wait + 1  : 0;
        AWREADY = AWVALID && (aw_wait > aw_dly[beat]);
        WREADY  = WVALID  && (w_wait  > w_dly[beat]);
        aw_pend = AWVALID && AWREADY; aw_pend_addr = AWADDR;
        w_pend  = WVALID && WREADY;   w_pend_data  = WDATA; w_pend_beat = beat;
        BVALID  = (stray_b && !busy) || (aw_done && w_done && !bhold[beat]);
        BRESP   = bresp_cfg[beat];
        b_pend  = BVALID && BREADY;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cfg(input int a0, w0, a1, w1, input logic [1:0] r0, r1, input bit h0, h1);
    aw_dly[0] = a0; w_dly[0] = w0; aw_dly[1] = a1; w_dly[1] = w1;
    bresp_cfg[0] = r0; bresp_cfg[1] = r1; bhold[0] = h0; bhold[1] = h1;
  endtask

  // Returns negedges from accept to the done cycle, or -1 if done never came.
  task automatic run_pkt(input logic [31:0] w, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!pkt_ready && g < 100) begin @(negedge clk); g++; end
    pkt_valid = 1'b1; pkt_data = w;
    @(negedge clk);
    pkt_valid = 1'b0; pkt_data = 32'hDEAD_BEEF;
    lat = 1;
    while (!done && lat < 300) begin @(negedge clk); lat++; end
    if (!done) lat = -1;
  endtask

  task automatic do_reset(input bit check);
    rst = 1'b0; pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (check) begin
      chk("rst pkt_ready", pkt_ready, 0);  chk("rst AWVALID", AWVALID, 0);
      chk("rst WVALID", WVALID, 0);        chk("rst BREADY", BREADY, 0);
      chk("rst AWADDR", AWADDR, 0);        chk("rst WDATA", WDATA, 0);
      chk("rst WSTRB", WSTRB, 4'hF);       chk("rst busy", busy, 0);
      chk("rst done", done, 0);            chk("rst last_resp", last_resp, 0);
      chk("rst valid_cnt", valid_cnt, 0);  chk("rst invalid_cnt", invalid_cnt, 0);
      chk("rst err_cnt", err_cnt, 0);      chk("rst timeout_flag", timeout_flag, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    if (check) chk("pkt_ready first IDLE clock", pkt_ready, 1);
  endtask

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  typedef struct {
    logic [31:0] word;
    int          a0, w0, a1, w1;
    logic [1:0]  r0, r1;
    bit          h0, h1;
    int          kind;      // 0 valid, 1 invalid, 2 error
    logic [1:0]  exp_last;
    int          exp_cmt;   // commit beats issued
    int          exp_lat;   // negedges from accept to done
    int          exp_brun;  // longest BREADY-high run
    bit          exp_tmo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, ev, ei, ee, aw0, w0, c0, q0, acc, dn;
    rst = 1'b0; pkt_valid = 1'b0; pkt_data = '0; stray_b = 0;
    set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    vecs[0] = '{32'hA512_3456, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 5,  1,  0};
    vecs[1] = '{32'h3C00_0000, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 2'b01, 1, 5,  1,  0};
    vecs[2] = '{32'hA5AB_CDEF, 3, 0, 0, 3, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 11, 1,  0};
    vecs[3] = '{32'hA500_0003, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 2, 2'b10, 0, 3,  1,  0};
    vecs[4] = '{32'hA500_0004, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 2, 2'b11, 1, 5,  1,  0};
    vecs[5] = '{32'hA500_0005, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2, 2'b11, 1, 68, 64, 1};
    vecs[6] = '{32'hA500_0006, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 1, 5,  1,  0};
    vecs[7] = '{32'hA500_0007, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2, 2'b11, 0, 66, 64, 1};

    do_reset(1);

    // BVALID outside a response state must be ignored.
    stray_b = 1; dn = 0; acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dn++;
      if (BREADY) acc++;
    end
    stray_b = 0;
    chk("stray B done pulses", dn, 0);
    chk("stray B BREADY cycles", acc, 0);
    chk("stray B err_cnt", err_cnt, 0);

    ev = 0; ei = 0; ee = 0;
    foreach (vecs[i]) begin
      set_cfg(vecs[i].a0, vecs[i].w0, vecs[i].a1, vecs[i].w1,
              vecs[i].r0, vecs[i].r1, vecs[i].h0, vecs[i].h1);
      aw0 = n_aw_hs; w0 = n_w_hs; c0 = n_cmt_aw;
      run_pkt(vecs[i].word, lat);
      case (vecs[i].kind)
        0: ev++;
        1: ei++;
        default: ee++;
      endcase
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d pkt_ready in done cycle", i), pkt_ready, 1);
      chk($sformatf("v%0d busy in done cycle", i), busy, 0);
      chk($sformatf("v%0d last_resp", i), last_resp, vecs[i].exp_last);
      chk($sformatf("v%0d valid_cnt", i), valid_cnt, ev);
      chk($sformatf("v%0d invalid_cnt", i), invalid_cnt, ei);
      chk($sformatf("v%0d err_cnt", i), err_cnt, ee);
      chk($sformatf("v%0d timeout_flag", i), timeout_flag, vecs[i].exp_tmo);
      chk($sformatf("v%0d commit beats", i), n_cmt_aw - c0, vecs[i].exp_cmt);
      chk($sformatf("v%0d AW beats", i), n_aw_hs - aw0, 1 + vecs[i].exp_cmt);
      chk($sformatf("v%0d W beats", i), n_w_hs - w0, 1 + vecs[i].exp_cmt);
      chk($sformatf("v%0d BREADY run", i), brun_max, vecs[i].exp_brun);
      chk($sformatf("v%0d cnt2 valid", i), d2_valid_cnt, sat3(ev));
      chk($sformatf("v%0d cnt2 err", i), d2_err_cnt, sat3(ee));
      if (vecs[i].exp_cmt > 0)
        chk($sformatf("v%0d commit WDATA", i), cmt_q[$], vecs[i].word);
      @(negedge clk);
      chk($sformatf("v%0d done pulse width", i), done, 0);
    end
    chk("VALID dropped after own handshake", n_drop_err, 0);
    chk("AWADDR/WDATA stable until handshake", n_stab_err, 0);

    // Source word held across a busy period; data changes while busy are ignored.
    set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    q0 = cmt_q.size(); acc = 0; dn = 0;
    @(negedge clk);
    while (!pkt_ready) @(negedge clk);
    pkt_valid = 1'b1; pkt_data = 32'hA511_1111;
    for (int k = 0; k < 10; k++) begin
      if (pkt_valid && pkt_ready) acc++;
      if (done) dn++;
      if (k == 2) pkt_data = 32'h3C22_2222;
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    lat = 0;
    while (!done && lat < 50) begin @(negedge clk); lat++; end
    chk("held word accepts", acc, 2);
    chk("held word done seen in window", dn, 1);
    chk("held word second done", done, 1);
    chk("held word commit count", cmt_q.size() - q0, 2);
    if (cmt_q.size() - q0 == 2) begin
      chk("held word first WDATA", cmt_q[q0], 32'hA511_1111);
      chk("held word second WDATA", cmt_q[q0 + 1], 32'h3C22_2222);
    end
    chk("held word valid_cnt", valid_cnt, ev + 2);

    // Saturation on the 2-bit copy.
    do_reset(0);
    for (int k = 0; k < 5; k++) run_pkt(32'hA500_0100 + k, lat);
    chk("sat wide valid_cnt", valid_cnt, 5);
    chk("sat 2-bit valid_cnt", d2_valid_cnt, 3);
    chk("sat 2-bit err_cnt", d2_err_cnt, 0);

    // Async reset while parked in CMT_REQ.
    set_cfg(0, 0, 20, 20, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    while (!pkt_ready) @(negedge clk);
    pkt_valid = 1'b1; pkt_data = 32'hA5CC_CCCC;
    @(negedge clk);
    pkt_valid = 1'b0;
    lat = 0;
    while (!(AWVALID && AWADDR == 32'h4) && lat < 50) begin @(negedge clk); lat++; end
    chk("reached CMT_REQ", AWVALID && AWADDR == 32'h4, 1);
    #2 rst = 1'b0;
    #1;
    chk("async AWVALID", AWVALID, 0);    chk("async WVALID", WVALID, 0);
    chk("async BREADY", BREADY, 0);      chk("async busy", busy, 0);
    chk("async pkt_ready", pkt_ready, 0); chk("async AWADDR", AWADDR, 0);
    chk("async valid_cnt", valid_cnt, 0); chk("async cnt2 valid", d2_valid_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    set_cfg(0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) dn++; end
    chk("lost packet no done", dn, 0);
    chk("lost packet not counted", valid_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
